entity_update_scheduler: RTL and testbench

ENTITY_UPDATE_SCHEDULER -- requirements
Module: entity_update_scheduler

---
 rtl/entity_update_scheduler_pkg.sv | 7 +
 rtl/entity_update_scheduler_rr_arbiter.sv | 33 +++
 rtl/entity_update_scheduler.sv | 97 +++++++++
 tb/tb_entity_update_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/entity_update_scheduler_pkg.sv
// entity_update_scheduler_pkg: shared widths, empty-channel entity value and FSM states
package entity_update_scheduler_pkg;
   localparam int ENTITY_W = 14;
   localparam int NUM_SLOTS = 9;
   localparam logic [13:0] EMPTY_ENTITY = 14'h3C00;
   typedef enum logic [1:0] {IDLE, ACK, COMMIT} state_t;
endpackage

// File: rtl/entity_update_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, pointer moves past the winner on accept
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         accept,
   output logic [N-1:0] grant
);
   localparam int PW = N > 1 ? $clog2(N) : 1;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   int idx;
   // scan from the highest offset down so the nearest requester at or after ptr wins
   always_comb begin
      grant = '0;
      gidx = ptr;
      idx = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            grant = '0;
            grant[idx] = 1'b1;
            gidx = PW'(idx);
         end
      end
   end
   // priority restarts just after the requester that was granted
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (accept && |req) ptr <= int'(gidx) == N - 1 ? '0 : gidx + 1'b1;
endmodule

// File: rtl/entity_update_scheduler.sv
// entity_update_scheduler: arbitrated writes into a shadow entity set, copied to the active set each frame
module entity_update_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int NUM_SLOTS = entity_update_scheduler_pkg::NUM_SLOTS,
   parameter int ENTITY_W = entity_update_scheduler_pkg::ENTITY_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [4*NUM_REQ-1:0]          req_slot,
   input  logic [ENTITY_W*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          err_slot,
   input  logic                          frame_start,
   output logic [ENTITY_W*NUM_SLOTS-1:0] entity_out,
   output logic                          commit,
   output logic [7:0]                    frame_count
);
   import entity_update_scheduler_pkg::*;
   state_t state;
   logic commit_pending;
   logic accept;
   logic bad_slot;
   logic [NUM_REQ-1:0] grant;
   logic [3:0] sel_slot;
   logic [ENTITY_W-1:0] sel_data;
   logic [ENTITY_W-1:0] shadow [NUM_SLOTS];
   logic [ENTITY_W-1:0] active [NUM_SLOTS];

   assign accept = state == IDLE && !frame_start && !commit_pending && |req;
   assign bad_slot = int'(sel_slot) >= NUM_SLOTS;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .accept(accept),
      .grant(grant)
   );

   // route the granted requester's slot index and entity word
   always_comb begin
      sel_slot = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) begin
            sel_slot = req_slot[4*i +: 4];
            sel_data = req_data[ENTITY_W*i +: ENTITY_W];
         end
   end

   // control FSM: commit beats writes, one write per two cycles, frame pulses never lost
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         ack <= '0;
         err_slot <= 1'b0;
         commit <= 1'b0;
         commit_pending <= 1'b0;
         frame_count <= '0;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            shadow[k] <= ENTITY_W'(EMPTY_ENTITY);
            active[k] <= ENTITY_W'(EMPTY_ENTITY);
         end
      end else begin
         ack <= '0;
         err_slot <= 1'b0;
         commit <= 1'b0;
         case (state)
            IDLE:
               if (frame_start || commit_pending) state <= COMMIT;
               else if (|req) begin
                  state <= ACK;
                  ack <= grant;
                  err_slot <= bad_slot;
                  for (int k = 0; k < NUM_SLOTS; k++)
                     if (int'(sel_slot) == k) shadow[k] <= sel_data;
               end
            ACK: begin
               state <= IDLE;
               if (frame_start) commit_pending <= 1'b1;
            end
            COMMIT: begin
               state <= IDLE;
               for (int k = 0; k < NUM_SLOTS; k++) active[k] <= shadow[k];
               frame_count <= frame_count + 8'd1;
               commit <= 1'b1;
               commit_pending <= frame_start;
            end
            default: state <= IDLE;
         endcase
      end

   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_out
      assign entity_out[ENTITY_W*k +: ENTITY_W] = active[k];
   end
endmodule

// File: tb/tb_entity_update_scheduler.sv
// tb_entity_update_scheduler: table-driven writes, scoreboarded acks and multi-cycle corner sequences
module tb_entity_update_scheduler;
   localparam logic [13:0] EMPTY = 14'h3C00;

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] req;
   logic [15:0] req_slot;
   logic [55:0] req_data;
   logic [3:0] ack;
   logic err_slot;
   logic frame_start;
   logic [125:0] entity_out;
   logic commit;
   logic [7:0] frame_count;

   entity_update_scheduler dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .req_slot(req_slot),
      .req_data(req_data),
      .ack(ack),
      .err_slot(err_slot),
      .frame_start(frame_start),
      .entity_out(entity_out),
      .commit(commit),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [3:0] ack; logic err;} exp_t;
   typedef struct {int r; logic [3:0] slot; logic [13:0] data; logic err;} vec_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;
   int commits = 0;
   logic [13:0] m_shadow [9];
   logic [13:0] m_active [9];
   logic [7:0] m_fc;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [125:0] exp_out();
      logic [125:0] v;
      for (int k = 0; k < 9; k++) v[14*k +: 14] = m_active[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 9; k++) begin
         m_shadow[k] = EMPTY;
         m_active[k] = EMPTY;
      end
      m_fc = 8'd0;
   endtask

   task automatic model_commit();
      for (int k = 0; k < 9; k++) m_active[k] = m_shadow[k];
      m_fc = m_fc + 8'd1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (commit) commits++;
      if (rst_n && (ack != 4'd0 || err_slot)) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: got ack=%b err=%b with nothing expected", ack, err_slot);
         end else begin
            e = sb.pop_front();
            check("ack_err", {123'd0, ack, err_slot}, {123'd0, e.ack, e.err});
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      frame_start = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_write(input int r, input logic [3:0] slot, input logic [13:0] data, input logic err);
      exp_t e;
      logic got;
      e.ack = 4'b0001 << r;
      e.err = err;
      sb.push_back(e);
      req_slot[4*r +: 4] = slot;
      req_data[14*r +: 14] = data;
      req[r] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = ack[r];
      end
      req[r] = 1'b0;
      check("ack_within_bound", {127'd0, got}, 128'd1);
      if (!err) m_shadow[slot] = data;
      @(negedge clk);
   endtask

   task automatic commit_pulse(input logic chk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      if (chk) begin
         check("commit_early", {127'd0, commit}, 128'd0);
         check("out_before_commit", {2'd0, entity_out}, {2'd0, exp_out()});
      end
      @(negedge clk);
      model_commit();
      if (chk) begin
         check("commit_pulse", {127'd0, commit}, 128'd1);
         check("out_after_commit", {2'd0, entity_out}, {2'd0, exp_out()});
         check("frame_count", {120'd0, frame_count}, {120'd0, m_fc});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int cyc;
      int nack;
      int ack_cyc[5];
      int c0;
      vecs[0] = '{2, 4'd3, 14'h0512, 1'b0};
      vecs[1] = '{0, 4'd12, 14'h1234, 1'b1};
      vecs[2] = '{1, 4'd0, 14'h2AFF, 1'b0};
      vecs[3] = '{3, 4'd8, 14'h3C55, 1'b0};
      vecs[4] = '{0, 4'd9, 14'h0ABC, 1'b1};
      vecs[5] = '{3, 4'd15, 14'h1111, 1'b1};
      vecs[6] = '{1, 4'd3, 14'h0777, 1'b0};
      vecs[7] = '{0, 4'd7, 14'h3FFF, 1'b0};
      rst_n = 1'b0;
      req = '0;
      req_slot = '0;
      req_data = '0;
      frame_start = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_out", {2'd0, entity_out}, {2'd0, {9{EMPTY}}});
      check("reset_frame_count", {120'd0, frame_count}, 128'd0);
      check("reset_ack", {124'd0, ack}, 128'd0);
      check("reset_commit_err", {126'd0, commit, err_slot}, 128'd0);
      commit_pulse(1'b1);

      for (int i = 0; i < 8; i++) begin
         do_write(vecs[i].r, vecs[i].slot, vecs[i].data, vecs[i].err);
         check("shadow_not_visible", {2'd0, entity_out}, {2'd0, exp_out()});
         commit_pulse(1'b1);
      end
      check("slot3_last_write", {114'd0, entity_out[42 +: 14]}, {114'd0, 14'h0777});

      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         req_slot[4*i +: 4] = 4'(i + 4);
         req_data[14*i +: 14] = 14'h0100 * 14'(i + 1) + 14'(i);
         m_shadow[i + 4] = 14'h0100 * 14'(i + 1) + 14'(i);
         e.ack = 4'b0001 << i;
         e.err = 1'b0;
         sb.push_back(e);
      end
      sb.push_back('{ack: 4'b0001, err: 1'b0});
      req = 4'hF;
      nack = 0;
      for (cyc = 0; cyc < 30 && nack < 5; cyc++) begin
         @(negedge clk);
         if (ack != 4'd0) begin
            ack_cyc[nack] = cyc;
            nack++;
            if (nack == 5) req = '0;
         end
      end
      req = '0;
      check("rr_ack_count", 128'(nack), 128'd5);
      for (int j = 1; j < 5 && j < nack; j++)
         check("rr_alternate_cycles", 128'(ack_cyc[j] - ack_cyc[j-1]), 128'd2);
      @(negedge clk);
      commit_pulse(1'b1);

      sb.push_back('{ack: 4'b0010, err: 1'b0});
      req_slot[7:4] = 4'd2;
      req_data[27:14] = 14'h2222;
      req[1] = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("commit_first_no_ack", {124'd0, ack}, 128'd0);
      @(negedge clk);
      model_commit();
      check("commit_before_write", {127'd0, commit}, 128'd1);
      check("commit_excludes_deferred", {2'd0, entity_out}, {2'd0, exp_out()});
      check("deferred_no_ack_yet", {124'd0, ack}, 128'd0);
      @(negedge clk);
      check("deferred_ack1", {124'd0, ack}, 128'h2);
      req[1] = 1'b0;
      m_shadow[2] = 14'h2222;
      c0 = commits;
      frame_start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      frame_start = 1'b0;
      repeat (8) @(negedge clk);
      model_commit();
      check("pending_single_commit", 128'(commits - c0), 128'd1);
      check("pending_commit_out", {2'd0, entity_out}, {2'd0, exp_out()});
      check("pending_frame_count", {120'd0, frame_count}, {120'd0, m_fc});

      do_reset();
      for (int i = 0; i < 255; i++) commit_pulse(1'b0);
      check("frame_count_255", {120'd0, frame_count}, 128'd255);
      commit_pulse(1'b0);
      check("frame_count_wrap", {120'd0, frame_count}, 128'd0);

      do_write(2, 4'd1, 14'h0ABC, 1'b0);
      commit_pulse(1'b1);
      req_slot[15:12] = 4'd2;
      req_data[55:42] = 14'h1357;
      req[3] = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      model_reset();
      check("reset_mid_ack_no_ack", {124'd0, ack}, 128'd0);
      check("reset_mid_ack_out", {2'd0, entity_out}, {2'd0, {9{EMPTY}}});
      check("reset_mid_ack_count", {120'd0, frame_count}, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      commit_pulse(1'b1);
      check("sb_drained", 128'(sb.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
